// File: rtl/uart_frame_err_injector.sv
// Inline UART frame tracker that inverts the parity bit and/or first stop bit
// of selected frames on a TXD line; keeps saturating frame/error counters.
module uart_frame_err_injector #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             TXD_IN,
  output logic             TXD_OUT,
  input  logic [1:0]       MODE,
  input  logic             GEN_PAR_ERR,
  input  logic             GEN_FRT_ERR,
  input  logic [CNT_W-1:0] PERIOD,
  input  logic             ARM,
  input  logic             CNT_CLR,
  output logic             ARMED,
  output logic             INJ_ACTIVE,
  output logic [CNT_W-1:0] FRAME_CNT,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam int            TW      = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF  = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] T_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    D_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    S_LAST  = 4'(STOP_BITS - 1);
  localparam bit            HAS_PAR = (PARITY_EN != 0);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  state_t           r_state;
  logic [TW-1:0]    r_timer;
  logic [3:0]       r_bit;
  logic             r_prev;
  logic             r_lat_par;
  logic             r_lat_frt;
  logic             r_txd;
  logic             r_inj;
  logic             r_armed;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_per_cnt;

  logic             w_inv;
  logic             w_decide;
  logic             w_bit_end;
  logic [CNT_W-1:0] w_per_next;
  logic             w_per_hit;
  logic             w_sel;
  logic             w_par;
  logic             w_frt;
  logic             w_corrupt;
  logic             w_consume;

  always_comb begin
    w_inv      = ((r_state == ST_PARITY) && r_lat_par) ||
                 ((r_state == ST_STOP) && (r_bit == '0) && r_lat_frt);
    w_decide   = (r_state == ST_START) && (r_timer == T_HALF) && !TXD_IN;
    w_bit_end  = (r_timer == T_LAST);
    w_per_next = r_per_cnt + CNT_W'(1);
    w_per_hit  = (PERIOD != '0) && (w_per_next == PERIOD);
    case (MODE)
      2'b01:   w_sel = r_armed;
      2'b10:   w_sel = w_per_hit;
      2'b11:   w_sel = 1'b1;
      default: w_sel = 1'b0;
    endcase
    w_par     = w_sel && GEN_PAR_ERR && HAS_PAR;
    w_frt     = w_sel && GEN_FRT_ERR;
    w_corrupt = w_par || w_frt;
    w_consume = w_decide && w_corrupt && (MODE == 2'b01);
  end

  // r_prev resets low so a line still low after reset cannot look like a start.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_bit       <= '0;
      r_prev      <= 1'b0;
      r_lat_par   <= 1'b0;
      r_lat_frt   <= 1'b0;
      r_txd       <= 1'b1;
      r_inj       <= 1'b0;
      r_armed     <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
      r_per_cnt   <= '0;
    end else begin
      r_prev  <= TXD_IN;
      r_txd   <= TXD_IN ^ w_inv;
      r_inj   <= w_inv;
      r_armed <= ARM | (r_armed & ~w_consume);

      if (CNT_CLR) begin
        r_frame_cnt <= '0;
        r_err_cnt   <= '0;
        r_per_cnt   <= '0;
      end else if (w_decide) begin
        if (r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        if (w_corrupt && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
        if (MODE == 2'b10) r_per_cnt <= w_per_hit ? '0 : w_per_next;
      end

      if (r_state != ST_IDLE) r_timer <= w_bit_end ? '0 : r_timer + TW'(1);

      // The first low cycle is spent in IDLE, so START begins at bit position 1.
      case (r_state)
        ST_IDLE: begin
          if (!TXD_IN && r_prev) begin
            r_state <= ST_START;
            r_timer <= TW'(1);
          end
        end
        ST_START: begin
          if ((r_timer == T_HALF) && TXD_IN) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
          end else begin
            if (w_decide) begin
              r_lat_par <= w_par;
              r_lat_frt <= w_frt;
            end
            if (w_bit_end) begin
              r_state <= ST_DATA;
              r_bit   <= '0;
            end
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit == D_LAST) begin
              r_bit   <= '0;
              r_state <= HAS_PAR ? ST_PARITY : ST_STOP;
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_bit   <= '0;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            if (r_bit == S_LAST) begin
              r_bit   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign TXD_OUT    = r_txd;
  assign INJ_ACTIVE = r_inj;
  assign ARMED      = r_armed;
  assign FRAME_CNT  = r_frame_cnt;
  assign ERR_CNT    = r_err_cnt;

endmodule

// File: tb/tb_uart_frame_err_injector.sv
// Bench for uart_frame_err_injector: frame-level model predicts the inverted
// windows and counters; every cycle is compared, plus literal spot checks.
module tb_uart_frame_err_injector;

  localparam int C    = 16;
  localparam int NB   = 11;
  localparam int FL   = C * NB;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;
  localparam int HN   = 16384;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          TXD_IN = 1'b1;
  logic [1:0]    MODE = 2'b00;
  logic          GEN_PAR_ERR = 1'b0;
  logic          GEN_FRT_ERR = 1'b0;
  logic [CW-1:0] PERIOD = '0;
  logic          ARM = 1'b0;
  logic          CNT_CLR = 1'b0;
  logic          TXD_OUT;
  logic          ARMED;
  logic          INJ_ACTIVE;
  logic [CW-1:0] FRAME_CNT;
  logic [CW-1:0] ERR_CNT;

  uart_frame_err_injector #(
    .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(1), .CLKS_PER_BIT(C), .CNT_W(CW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .TXD_IN(TXD_IN), .TXD_OUT(TXD_OUT), .MODE(MODE),
    .GEN_PAR_ERR(GEN_PAR_ERR), .GEN_FRT_ERR(GEN_FRT_ERR), .PERIOD(PERIOD),
    .ARM(ARM), .CNT_CLR(CNT_CLR), .ARMED(ARMED), .INJ_ACTIVE(INJ_ACTIVE),
    .FRAME_CNT(FRAME_CNT), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int m_frame = 0;
  int m_err   = 0;
  int m_per   = 0;
  bit m_armed = 1'b0;
  bit inv [HN];
  bit in_hist [HN];
  bit rst_hist [HN];
  bit out_hist [HN];
  bit inj_hist [HN];
  bit armed_hist [HN];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  logic e_out, e_inj;
  always @(negedge CLK) begin
    if (cyc < HN) begin
      in_hist[cyc]    = TXD_IN;
      rst_hist[cyc]   = RST_N;
      out_hist[cyc]   = TXD_OUT;
      inj_hist[cyc]   = INJ_ACTIVE;
      armed_hist[cyc] = ARMED;
      if (cyc >= 2) begin
        if (!RST_N || !rst_hist[cyc-1]) begin
          e_out = 1'b1;
          e_inj = 1'b0;
        end else begin
          e_out = in_hist[cyc-1] ^ inv[cyc-1];
          e_inj = inv[cyc-1];
        end
        chk("txd_out", int'(TXD_OUT), int'(e_out));
        chk("inj_active", int'(INJ_ACTIVE), int'(e_inj));
        chk("armed", int'(ARMED), int'(m_armed));
        chk("frame_cnt", int'(FRAME_CNT), m_frame);
        chk("err_cnt", int'(ERR_CNT), m_err);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_frame = 0;
    m_err   = 0;
    m_per   = 0;
    m_armed = 1'b0;
    for (int k = cyc; k < HN; k++) inv[k] = 1'b0;
  endtask

  // Frame-level selection rules, applied one cycle after the decision point.
  task automatic decide(input bit clr, input int t0);
    bit sel, par, frt;
    sel = 1'b0;
    case (MODE)
      2'b01: sel = m_armed;
      2'b10: begin
        m_per = (m_per + 1) % (MAXC + 1);
        if (PERIOD != 0 && m_per == int'(PERIOD)) begin
          sel   = 1'b1;
          m_per = 0;
        end
      end
      2'b11: sel = 1'b1;
      default: sel = 1'b0;
    endcase
    par = sel && GEN_PAR_ERR;
    frt = sel && GEN_FRT_ERR;
    if (m_frame < MAXC) m_frame++;
    if (par || frt) begin
      if (m_err < MAXC) m_err++;
      if (MODE == 2'b01) m_armed = 1'b0;
    end
    for (int i = 0; i < C; i++) begin
      if (par) inv[t0 + 9*C + i] = 1'b1;
      if (frt) inv[t0 + 10*C + i] = 1'b1;
    end
    if (clr) begin
      m_frame = 0;
      m_err   = 0;
      m_per   = 0;
    end
  endtask

  task automatic send(input logic [7:0] d, input int rst_at, input int rst_rel,
                      input bit clr_dec, output int t0);
    logic [NB-1:0] bits;
    bits = {1'b1, ^d, d, 1'b0};
    t0 = 0;
    for (int j = 0; j < FL; j++) begin
      tick();
      TXD_IN  = bits[j / C];
      if (j == 0) t0 = cyc;
      CNT_CLR = clr_dec && (j == C/2);
      if (j == C/2 + 1) decide(clr_dec, t0);
      if (j == rst_at) begin
        RST_N = 1'b0;
        model_reset();
      end
      if (j == rst_rel) RST_N = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      TXD_IN = 1'b1;
    end
  endtask

  task automatic arm_pulse();
    tick(); ARM = 1'b1;
    tick(); ARM = 1'b0; m_armed = 1'b1;
  endtask

  task automatic clear_cnt();
    tick(); CNT_CLR = 1'b1;
    tick(); CNT_CLR = 1'b0;
    m_frame = 0; m_err = 0; m_per = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t, g0;
    int tf [16];
    model_reset();
    repeat (3) tick();
    chk("rst_txd_out", int'(TXD_OUT), 1);
    chk("rst_armed", int'(ARMED), 0);
    chk("rst_frame_cnt", int'(FRAME_CNT), 0);
    RST_N = 1'b1;
    idle(5);

    // Continuous parity corruption of 0xA5 (even parity 0)
    MODE = 2'b11; GEN_PAR_ERR = 1'b1; GEN_FRT_ERR = 1'b0;
    send(8'hA5, -1, -1, 1'b0, t);
    idle(5);
    chk("t1_inj_before", int'(inj_hist[t+144]), 0);
    chk("t1_par_first", int'(out_hist[t+145]), 1);
    chk("t1_inj_first", int'(inj_hist[t+145]), 1);
    chk("t1_inj_last", int'(inj_hist[t+160]), 1);
    chk("t1_stop_clean", int'(out_hist[t+161]), 1);
    chk("t1_inj_after", int'(inj_hist[t+161]), 0);
    chk("t1_err", int'(ERR_CNT), 1);
    chk("t1_frame", int'(FRAME_CNT), 1);

    // Single-shot stop-bit corruption
    clear_cnt();
    MODE = 2'b01; GEN_PAR_ERR = 1'b0; GEN_FRT_ERR = 1'b1;
    arm_pulse();
    idle(3);
    send(8'h3C, -1, -1, 1'b0, tf[0]);
    send(8'h55, -1, -1, 1'b0, tf[1]);
    send(8'hFF, -1, -1, 1'b0, tf[2]);
    idle(5);
    chk("t2_stop_first", int'(out_hist[tf[0]+161]), 0);
    chk("t2_stop_last", int'(out_hist[tf[0]+176]), 0);
    chk("t2_f2_stop", int'(out_hist[tf[1]+161]), 1);
    chk("t2_armed_at_dec", int'(armed_hist[tf[0]+8]), 1);
    chk("t2_armed_after", int'(armed_hist[tf[0]+9]), 0);
    chk("t2_err", int'(ERR_CNT), 1);
    chk("t2_frame", int'(FRAME_CNT), 3);

    // False start glitch while armed
    arm_pulse();
    idle(3);
    tick(); TXD_IN = 1'b0; g0 = cyc;
    repeat (3) tick();
    tick(); TXD_IN = 1'b1;
    idle(30);
    chk("t3_out_pre", int'(out_hist[g0]), 1);
    chk("t3_out_lo0", int'(out_hist[g0+1]), 0);
    chk("t3_out_lo3", int'(out_hist[g0+4]), 0);
    chk("t3_out_hi", int'(out_hist[g0+5]), 1);
    chk("t3_armed", int'(ARMED), 1);
    chk("t3_frame", int'(FRAME_CNT), 3);

    // Periodic every 3rd frame, then PERIOD=0
    clear_cnt();
    MODE = 2'b10; PERIOD = 4'd3; GEN_PAR_ERR = 1'b1; GEN_FRT_ERR = 1'b0;
    idle(3);
    for (int i = 0; i < 9; i++) send(8'(i * 37 + 1), -1, -1, 1'b0, tf[i]);
    idle(5);
    chk("t4_f1_inj", int'(inj_hist[tf[0]+150]), 0);
    chk("t4_f3_inj", int'(inj_hist[tf[2]+150]), 1);
    chk("t4_f6_inj", int'(inj_hist[tf[5]+145]), 1);
    chk("t4_f7_inj", int'(inj_hist[tf[6]+145]), 0);
    chk("t4_f9_inj", int'(inj_hist[tf[8]+160]), 1);
    chk("t4_err", int'(ERR_CNT), 3);
    chk("t4_frame", int'(FRAME_CNT), 9);
    PERIOD = 4'd0;
    for (int i = 0; i < 4; i++) send(8'(i * 11 + 2), -1, -1, 1'b0, tf[i]);
    idle(5);
    chk("t4_p0_err", int'(ERR_CNT), 3);
    chk("t4_p0_frame", int'(FRAME_CNT), 13);

    // Reset in the middle of a corrupted frame; line stays low after release
    MODE = 2'b11; GEN_PAR_ERR = 1'b1; GEN_FRT_ERR = 1'b0;
    send(8'h00, 50, 60, 1'b0, t);
    idle(10);
    chk("t5_out_in_rst", int'(out_hist[t+55]), 1);
    chk("t5_out_tail", int'(out_hist[t+61]), 0);
    chk("t5_par_clean", int'(out_hist[t+150]), 0);
    chk("t5_inj_clean", int'(inj_hist[t+150]), 0);
    chk("t5_frame", int'(FRAME_CNT), 0);
    MODE = 2'b00;
    send(8'h81, -1, -1, 1'b0, t);
    idle(5);
    chk("t5_next_frame", int'(FRAME_CNT), 1);
    chk("t5_next_err", int'(ERR_CNT), 0);

    // Saturation
    clear_cnt();
    MODE = 2'b11; GEN_PAR_ERR = 1'b0; GEN_FRT_ERR = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(i), -1, -1, 1'b0, t);
    idle(5);
    chk("t6_frame_sat", int'(FRAME_CNT), 15);
    chk("t6_err_sat", int'(ERR_CNT), 15);

    // Clear coincident with the decision point
    send(8'h5A, -1, -1, 1'b1, t);
    idle(5);
    chk("t7_frame_clr", int'(FRAME_CNT), 0);
    chk("t7_err_clr", int'(ERR_CNT), 0);
    chk("t7_inj_stop", int'(inj_hist[t+161]), 1);

    idle(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
